// File: rtl/spicmd_ext.sv
// spicmd_ext -- SD-card SPI command engine.
//
// Frames a 6-byte SD command (0b01 + index, 32-bit argument, CRC7 trailer)
// onto a byte-level SPI shifter, then collects an R1, R1b, R2 or R3/R7
// response. It watches for an Ncr (response latency) timeout and an R1b
// busy-wait timeout.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_cmd_stb             command request, taken only while !o_busy
//   i_cmd_type            00 R1, 01 R1b, 10 R3/R7 (R1+4 bytes), 11 R2 (R1+1 byte)
//   i_cmd, i_cmd_data     command index and argument
//   o_busy                engine active
//   o_ll_stb, o_ll_byte   byte request to the SPI layer (taken when !i_ll_busy)
//   i_ll_busy             SPI layer busy
//   i_ll_stb, i_ll_byte   received byte, one per accepted byte, in order
//   o_cmd_sent            high from the 6th echo until the engine goes idle
//   o_done                one-cycle completion pulse
//   o_err                 [0] R1 timeout, [1] busy timeout
//   o_response            [39:32] R1, [31:0] tail bytes shifted in from the LSB
module spicmd_ext #(
  parameter bit OPT_CRC      = 1'b1,
  parameter int RESP_TIMEOUT = 8,
  parameter int LGBUSY       = 16,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_stb,
  input  logic [1:0]  i_cmd_type,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_data,
  output logic        o_busy,
  output logic        o_ll_stb,
  output logic [7:0]  o_ll_byte,
  input  logic        i_ll_busy,
  input  logic        i_ll_stb,
  input  logic [7:0]  i_ll_byte,
  output logic        o_cmd_sent,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic [39:0] o_response
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND      = 3'd1;
  localparam logic [2:0] WAIT_R1   = 3'd2;
  localparam logic [2:0] RX_TAIL   = 3'd3;
  localparam logic [2:0] BUSY_WAIT = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [7:0]        NCR_LAST   = 8'(RESP_TIMEOUT - 1);
  localparam logic [LGBUSY-1:0] BUSY_LIMIT = LGBUSY'(BUSY_TIMEOUT);
  localparam logic [4:0]        CRC_STEPS  = 5'd20;  // 40 bits, 2 per cycle

  logic [2:0]        state;
  logic [1:0]        r_type;
  logic [5:0]        r_cmd;
  logic [31:0]       r_arg;
  logic [39:0]       crc_sr;
  logic [6:0]        crc;
  logic [4:0]        crc_cnt;
  logic [2:0]        tx_idx;     // byte being presented, 6 = fill
  logic [2:0]        echo_cnt;
  logic [1:0]        tail_cnt;
  logic [7:0]        ncr_cnt;
  logic [LGBUSY-1:0] busy_cnt;
  logic              cmd_sent;
  logic [1:0]        err;
  logic [39:0]       response;
  logic [7:0]        trailer;
  logic [7:0]        tx_byte;
  logic              crc_ready;
  logic              hold_trailer;
  logic              byte_taken;
  logic [1:0]        tail_last;

  // One serial CRC7 step, polynomial x^7 + x^3 + 1, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
  endfunction

  assign crc_ready    = !OPT_CRC || (crc_cnt == CRC_STEPS);
  // The trailer may not go out before the CRC has finished.
  assign hold_trailer = (state == SEND) && (tx_idx == 3'd5) && !crc_ready;
  assign o_busy       = (state != IDLE) && (state != DONE);
  assign o_ll_stb     = o_busy && !hold_trailer;
  assign byte_taken   = o_ll_stb && !i_ll_busy;
  assign o_ll_byte    = tx_byte;
  assign o_done       = (state == DONE);
  assign o_cmd_sent   = cmd_sent;
  assign o_err        = err;
  assign o_response   = response;
  assign tail_last    = (r_type == 2'b10) ? 2'd3 : 2'd0;

  always_comb begin
    if (OPT_CRC)              trailer = {crc, 1'b1};
    else if (r_cmd == 6'd0)   trailer = 8'h95;
    else if (r_cmd == 6'd8)   trailer = 8'h87;
    else                      trailer = 8'h01;
  end

  always_comb begin
    tx_byte = 8'hff;
    if (state == SEND) begin
      case (tx_idx)
        3'd0:    tx_byte = {2'b01, r_cmd};
        3'd1:    tx_byte = r_arg[31:24];
        3'd2:    tx_byte = r_arg[23:16];
        3'd3:    tx_byte = r_arg[15:8];
        3'd4:    tx_byte = r_arg[7:0];
        3'd5:    tx_byte = trailer;
        default: tx_byte = 8'hff;
      endcase
    end
  end

  // NOTE: command latches and the CRC datapath carry no reset; they are always
  // reloaded when a command is accepted, and crc_cnt (reset) gates their use.
  always_ff @(posedge i_clk) begin
    if ((state == IDLE) && i_cmd_stb) begin
      r_type <= i_cmd_type;
      r_cmd  <= i_cmd;
      r_arg  <= i_cmd_data;
      crc_sr <= {2'b01, i_cmd, i_cmd_data};
      crc    <= 7'h00;
    end else if (crc_cnt != CRC_STEPS) begin
      crc    <= crc7_step(crc7_step(crc, crc_sr[39]), crc_sr[38]);
      crc_sr <= {crc_sr[37:0], 2'b00};
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values of the counters it compares against.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      crc_cnt  <= CRC_STEPS;
      tx_idx   <= 3'd0;
      echo_cnt <= 3'd0;
      tail_cnt <= 2'd0;
      ncr_cnt  <= 8'd0;
      busy_cnt <= '0;
      cmd_sent <= 1'b0;
      err      <= 2'b00;
      response <= '1;
    end else begin
      if ((state != IDLE) && (crc_cnt != CRC_STEPS))
        crc_cnt <= crc_cnt + 5'd1;

      case (state)
        IDLE: begin
          if (i_cmd_stb) begin
            state    <= SEND;
            crc_cnt  <= 5'd0;
            tx_idx   <= 3'd0;
            echo_cnt <= 3'd0;
            err      <= 2'b00;
            response <= '1;
          end
        end

        SEND: begin
          if (byte_taken && (tx_idx != 3'd6))
            tx_idx <= tx_idx + 3'd1;
          // Echoes of the command bytes carry nothing useful.
          if (i_ll_stb) begin
            echo_cnt <= echo_cnt + 3'd1;
            if (echo_cnt == 3'd5) begin
              cmd_sent <= 1'b1;
              ncr_cnt  <= 8'd0;
              state    <= WAIT_R1;
            end
          end
        end

        WAIT_R1: begin
          if (i_ll_stb) begin
            if (!i_ll_byte[7]) begin
              response[39:32] <= i_ll_byte;
              tail_cnt        <= 2'd0;
              busy_cnt        <= '0;
              case (r_type)
                2'b00: begin state <= DONE; cmd_sent <= 1'b0; end
                2'b01:       state <= BUSY_WAIT;
                default:     state <= RX_TAIL;
              endcase
            end else if (ncr_cnt == NCR_LAST) begin
              err[0]   <= 1'b1;
              cmd_sent <= 1'b0;
              state    <= DONE;
            end else begin
              ncr_cnt <= ncr_cnt + 8'd1;
            end
          end
        end

        RX_TAIL: begin
          if (i_ll_stb) begin
            response[31:0] <= {response[23:0], i_ll_byte};
            tail_cnt       <= tail_cnt + 2'd1;
            if (tail_cnt == tail_last) begin
              cmd_sent <= 1'b0;
              state    <= DONE;
            end
          end
        end

        BUSY_WAIT: begin
          if (i_ll_stb) begin
            if (i_ll_byte != 8'h00) begin
              cmd_sent <= 1'b0;
              state    <= DONE;
            end else if (busy_cnt >= BUSY_LIMIT) begin
              // This zero is the one past the limit; the counter stops here.
              err[1]   <= 1'b1;
              cmd_sent <= 1'b0;
              state    <= DONE;
            end else begin
              busy_cnt <= busy_cnt + LGBUSY'(1);
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spicmd_ext.md
Name: spicmd_ext

Overview:
Parametrised SD-card SPI command engine; successor to the fixed single-mode command sender.
- Frames a 6-byte SD command (start bits, index, argument, CRC7 trailer) onto the shared SPI byte-level interface.
- Collects R1, R1b, R2 or R3/R7 responses, with response-latency (Ncr) and busy timeouts and error reporting.
- Sits between the SD controller's register/FSM layer and the low-level SPI byte shifter.

Parameters:
OPT_CRC, 1, 1: compute CRC7 of the command. 0: fixed trailer 8'h95 for CMD0, 8'h87 for CMD8, 8'h01 otherwise.
RESP_TIMEOUT, 8, max fill bytes after the command waiting for R1 (Ncr limit), range 1..255.
LGBUSY, 16, width of the busy-wait byte counter.
BUSY_TIMEOUT, 65535, max 8'h00 bytes tolerated in R1b busy wait, must fit in LGBUSY bits.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_cmd_stb  in  1  command request, accepted only when !o_busy
i_cmd_type  in  2  00 R1, 01 R1b, 10 R3/R7 (R1+4 bytes), 11 R2 (R1+1 byte)
i_cmd  in  6  command index
i_cmd_data  in  32  command argument
o_busy  out  1  engine active
o_ll_stb  out  1  byte request to SPI layer
o_ll_byte  out  8  byte to transmit
i_ll_busy  in  1  SPI layer busy; byte accepted when o_ll_stb && !i_ll_busy
i_ll_stb  in  1  received-byte strobe, exactly one per accepted byte, in order
i_ll_byte  in  8  received byte
o_cmd_sent  out  1  high from the 6th echo byte received until idle
o_done  out  1  one-cycle completion pulse
o_err  out  2  [0] R1 timeout, [1] busy timeout; valid with o_done, held until next accepted command
o_response  out  40  [39:32] R1; [31:0] tail bytes shifted in from LSB

Behaviour:
- Reset values: o_busy=0, o_ll_stb=0, o_ll_byte=8'hff, o_cmd_sent=0, o_done=0, o_err=0, o_response=40'hff_ffff_ffff.
- Reset mid-operation: return to IDLE next cycle and drop o_ll_stb. Echoes still in flight from the SPI layer are ignored in IDLE.
- States: IDLE, SEND, WAIT_R1, RX_TAIL, BUSY_WAIT, DONE.
- IDLE:
  - i_cmd_stb latches type, index and argument; o_busy=1 next cycle; o_err cleared; o_response set to all ones.
  - i_cmd_stb is ignored while o_busy.
- SEND:
  - Presents 8'h40|cmd, arg[31:24], arg[23:16], arg[15:8], arg[7:0], trailer.
  - o_ll_byte advances only on acceptance.
  - OPT_CRC=1: CRC7 (polynomial x^7+x^3+1) is computed 2 bits/cycle over 40 bits (20 cycles from acceptance); trailer = {crc7,1'b1}. o_ll_stb is held low before the trailer until CRC completes.
  - After the trailer, o_ll_stb stays high with 8'hff fill until DONE.
  - The first 6 echoes (i_ll_stb) are discarded. The 6th sets o_cmd_sent and enters WAIT_R1.
- WAIT_R1:
  - Each echo with bit7=0 is R1: stored in [39:32]. Next state is DONE for type 00, RX_TAIL for 10/11, BUSY_WAIT for 01.
  - Each 8'hff-class echo (bit7=1) increments the Ncr counter. Reaching RESP_TIMEOUT sets o_err[0] and enters DONE; R1 stays 8'hff.
- RX_TAIL: collects 4 (type 10) or 1 (type 11) echoes, each shifted into o_response[31:0] as {[23:0],byte}.
- BUSY_WAIT:
  - First echo !=8'h00 enters DONE.
  - Each 8'h00 increments the busy counter. Exceeding BUSY_TIMEOUT sets o_err[1] and enters DONE.
  - The counter saturates, never wraps.
- DONE:
  - o_ll_stb low; o_done=1 for one cycle; o_busy=0 the same cycle; o_cmd_sent=0.
  - Returns to IDLE, so a new i_cmd_stb is accepted one cycle after o_done.
- Echo arrives in the same cycle the engine would issue a fill byte: both are processed. Fill bytes issued beyond the final response are harmless.
- i_ll_stb arriving in IDLE or DONE is ignored.

Test Plan:
- CMD0, arg 0, type 00, OPT_CRC=1, echoes ff×6 then ff,01 -> tx 40 00 00 00 00 95; o_response=40'h01_ffff_ffff; o_err=0; one o_done pulse.
- CMD8, arg 32'h1AA, type 10, echoes R1=01 then 00 00 01 AA -> trailer 87; o_response=40'h01_0000_01AA. Repeat with OPT_CRC=0: same bytes.
- CMD17, type 00, RESP_TIMEOUT=8, all echoes 8'hff -> o_done after the 8th post-command echo; o_err=2'b01; R1 byte 8'hff.
- CMD24, type 01, R1=00, then 00×3, then ff -> o_done after the ff echo, o_err=0. Repeat with BUSY_TIMEOUT=4 and 00×10 -> o_err=2'b10.
- Random i_ll_busy backpressure (0–20 cycles/byte) -> transmitted byte order unchanged, no byte duplicated or dropped. i_cmd_stb while busy -> ignored.
- i_reset asserted mid-SEND and mid-BUSY_WAIT -> next cycle o_busy=0, o_ll_stb=0, o_response all ones. A fresh command then completes normally.
